// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MIPS32 memory-access stage.
// Holds the port FSM state encoding and the word-alignment check.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } mem_state_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_port_fsm.sv
// Data-memory port sequencer: presents a held request, waits for load data,
// and freezes the pipeline whenever an access is outstanding.
module dmem_port_fsm
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              we_i,
  input  logic [ADDR_W-3:0] word_addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              dmem_req_ready,
  input  logic              dmem_resp_valid,
  output logic              dmem_req_valid,
  output logic              dmem_req_we,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_wdata,
  output logic              resp_take_o,
  output logic              stall_m
);

  mem_state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = REQ;
      end
      REQ: begin
        // Stores are posted: acceptance completes them.
        if (dmem_req_ready) state_d = we_i ? IDLE : WAIT_RESP;
      end
      WAIT_RESP: begin
        if (dmem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_m        = (state_q != IDLE);
  assign dmem_req_valid = (state_q == REQ);
  assign resp_take_o    = (state_q == WAIT_RESP) && dmem_resp_valid;
  assign dmem_req_we    = we_i;
  assign dmem_req_addr  = {word_addr_i, 2'b00};
  assign dmem_req_wdata = wdata_i;

endmodule

// File: rtl/mem_access_stage.sv
// MIPS32 memory stage: M pipeline register, word load/store sequencing via
// dmem_port_fsm, and gated writeback / forwarding outputs.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] alu_out_e,
  input  logic [DATA_W-1:0] write_data_e,
  input  logic [4:0]        write_reg_e,
  input  logic              reg_write_e,
  input  logic              mem_to_reg_e,
  input  logic              mem_write_e,
  input  logic              mem_access_e,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_wdata,
  input  logic              dmem_resp_valid,
  input  logic [DATA_W-1:0] dmem_resp_rdata,
  output logic [ADDR_W-1:0] alu_out_m,
  output logic [DATA_W-1:0] read_data_m,
  output logic [4:0]        write_reg_m,
  output logic              reg_write_m,
  output logic              mem_to_reg_m,
  output logic [DATA_W-1:0] result_m,
  output logic              misalign_m,
  output logic              stall_m
);

  logic [ADDR_W-1:0] alu_out_q;
  logic [DATA_W-1:0] write_data_q;
  logic [DATA_W-1:0] read_data_q;
  logic [4:0]        write_reg_q;
  logic              reg_write_q;
  logic              mem_to_reg_q;
  logic              mem_write_q;
  logic              misalign_q;
  logic              resp_take;
  logic              start_access;
  logic              aligned_e;

  assign aligned_e    = is_word_aligned(alu_out_e[1:0]);
  assign start_access = mem_access_e && aligned_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q    <= '0;
      write_data_q <= '0;
      read_data_q  <= '0;
      write_reg_q  <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      // Upstream holds its outputs while stalled, so only latch when free.
      if (!stall_m) begin
        alu_out_q    <= alu_out_e;
        write_data_q <= write_data_e;
        write_reg_q  <= write_reg_e;
        reg_write_q  <= reg_write_e;
        mem_to_reg_q <= mem_to_reg_e;
        mem_write_q  <= mem_write_e;
        misalign_q   <= mem_access_e && !aligned_e;
      end
      if (resp_take) begin
        read_data_q <= dmem_resp_rdata;
      end
    end
  end

  dmem_port_fsm #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_fsm (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_access),
    .we_i            (mem_write_q),
    .word_addr_i     (alu_out_q[ADDR_W-1:2]),
    .wdata_i         (write_data_q),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_we     (dmem_req_we),
    .dmem_req_addr   (dmem_req_addr),
    .dmem_req_wdata  (dmem_req_wdata),
    .resp_take_o     (resp_take),
    .stall_m         (stall_m)
  );

  assign alu_out_m    = alu_out_q;
  assign read_data_m  = read_data_q;
  assign write_reg_m  = write_reg_q;
  assign mem_to_reg_m = mem_to_reg_q;
  assign misalign_m   = misalign_q;
  // Writeback fires only in the single IDLE cycle that completes the instruction.
  assign reg_write_m  = reg_write_q && !stall_m && !misalign_q;
  assign result_m     = mem_to_reg_q ? read_data_q : DATA_W'(alu_out_q);

endmodule
